if_next_pc_predictor: RTL and testbench
=======================================

Name: if_next_pc_predictor

Overview:
- Fetch-side consumer of the EX stage's golden next-PC (the other end of the `if_pc_golden` interface).
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and predicts the next fetch PC each cycle.
- Compares the prediction carried down the pipeline against the golden PC resolved in EX, trains the BTB, and issues a registered redirect/flush on mispredict.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2.
- IDX_W, $clog2(BTB_ENTRIES), index width; derived, do not override.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- if_pc  input  32  current fetch PC, word aligned
- if_stall  input  1  fetch held this cycle; prediction still driven, no state change caused by IF
- if_pred_pc  output  32  predicted next fetch PC
- ex_valid  input  1  EX holds a real, non-bubble instruction
- ex_is_ctrl  input  1  EX instruction is jal/jalr/branch (pcmux_sel != pc_plus4)
- ex_pc  input  32  PC of the EX instruction
- ex_pred_pc  input  32  prediction made for that instruction when it was fetched
- ex_pc_golden  input  32  golden next PC from EX
- redirect_valid  output  1  registered; fetch must load redirect_pc and flush IF/ID/EX
- redirect_pc  output  32  registered correct PC
- ready  output  1  high once BTB init completes

Behaviour:
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2].
- FSM states INIT, RUN, REDIRECT. Reset forces INIT with init_idx = 0.
- Reset values: redirect_valid = 0, redirect_pc = 0, ready = 0.
- INIT:
  - Each cycle clears valid[init_idx] and increments init_idx.
  - After BTB_ENTRIES cycles, goes to RUN and ready = 1 (ready is registered).
  - In INIT: if_pred_pc = if_pc + 4, updates are dropped, redirect is never raised.
- Prediction (combinational, all states):
  - hit = valid && tag match.
  - In RUN or REDIRECT, if_pred_pc = target when hit && ctr[1]; otherwise if_pc + 4.
- Training (RUN only, when ex_valid && ex_is_ctrl):
  - taken = (ex_pc_golden != ex_pc + 4).
  - Hit: ctr saturating +1 if taken, -1 if not taken. Target is overwritten with ex_pc_golden when taken.
  - Miss and taken: allocate the entry with valid = 1, new tag, target = ex_pc_golden, ctr = 2'b10.
  - Miss and not taken: no write.
- Mispredict (RUN only): ex_valid && ex_pred_pc != ex_pc_golden. Applies to non-ctrl instructions too, catching stale aliasing targets.
  - Next cycle: redirect_valid = 1, redirect_pc = ex_pc_golden, state = REDIRECT.
- REDIRECT:
  - Lasts exactly one cycle; the instruction in EX is wrong-path, so its training and mispredict are ignored.
  - Returns to RUN with redirect_valid = 0.
- Same-index lookup and write in one cycle: lookup sees pre-write contents.
- if_stall does not block training or redirect.
- rst asserted in any state returns to INIT next cycle and clears redirect_valid; BTB contents are invalidated by the sweep.
- Arithmetic: PC+4 wraps modulo 2^32; bits [1:0] of the target are stored as given.

Optional Feature:
- Macro: BTB_PERF_CNT_EN.
- Defined: adds outputs `perf_ctrl_cnt[31:0]` (count of trained ctrl instructions) and `perf_mispred_cnt[31:0]` (count of redirects issued).
  - Both reset to 0, wrap at 2^32, and do not count in INIT or REDIRECT.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package `rv32i_types`: typedef `btb_entry_t` (valid, tag, target, ctr) and enum `bpfsm_state_t` {INIT, RUN, REDIRECT}.
- Counter constants: CTR_WNT = 2'b01, CTR_WT = 2'b10.
- One natural sub-module: `sat_ctr2`, the combinational 2-bit saturating update.

Test Plan:
- Reset, then hold 16 cycles: ready rises on cycle 17. During INIT, if_pc = 0x100 gives if_pred_pc = 0x104.
- Branch at 0x200 to 0x240, taken, ex_pred_pc = 0x204: next cycle redirect_valid = 1, redirect_pc = 0x240. Later, if_pc = 0x200 gives if_pred_pc = 0x240 (ctr = 2'b10).
- Train the same branch not-taken twice (golden 0x204): first update gives ctr 01 and prediction 0x204. The redirect issued on the first update suppresses the second EX update in the REDIRECT cycle; verify the counter is not decremented by it.
- Aliasing: entry at 0x200 is valid; fetch 0x240 (same index when BTB_ENTRIES = 16) gives tag mismatch and predicts 0x244.
- Mispredict on the cycle after a redirect: no second redirect is raised.
- Assert rst while in REDIRECT: redirect_valid = 0 next cycle, ready = 0, and the previously trained 0x200 entry misses after init.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared fetch-side types: BTB entry layout, predictor FSM states and counter encodings.
package rv32i_types;

  localparam int unsigned TAG_W = 30;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is held zero-extended to a fixed width so the struct is independent of BTB depth.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    REDIRECT
  } bpfsm_state_t;

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
    return TAG_W'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Combinational 2-bit saturating counter update (taken counts up, not-taken counts down).
module sat_ctr2
  import rv32i_types::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
      default: ctr_o = taken_i ? CTR_ST  : CTR_WT;
    endcase
  end

endmodule

// File: rtl/if_next_pc_predictor.sv
// Next-fetch-PC predictor: direct-mapped BTB trained from EX golden PC, registered redirect on mispredict.
// Optional BTB_PERF_CNT_EN adds trained-ctrl and redirect event counters.
module if_next_pc_predictor
  import rv32i_types::*;
#(
  parameter  int unsigned BTB_ENTRIES = 16,
  localparam int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_stall,
  output logic [31:0] if_pred_pc,
  input  logic        ex_valid,
  input  logic        ex_is_ctrl,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_pred_pc,
  input  logic [31:0] ex_pc_golden,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        ready
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0] perf_ctrl_cnt,
  output logic [31:0] perf_mispred_cnt
`endif
);

  bpfsm_state_t     state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             ready_q, ready_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;

  btb_entry_t       btb_q [BTB_ENTRIES];
  btb_entry_t       if_entry, ex_entry, btb_wdata;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, taken;
  logic             train_c, mispred_c, clr_we, btb_we;
  logic [1:0]       ctr_upd;

  // Fetch stalls only freeze the PC source upstream; the predictor has no IF-side state.
  logic unused_if_stall;
  assign unused_if_stall = if_stall;

  assign if_idx   = if_pc[IDX_W+1:2];
  assign if_tag   = pc_tag(if_pc, IDX_W);
  assign if_entry = btb_q[if_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);

  assign ex_idx   = ex_pc[IDX_W+1:2];
  assign ex_tag   = pc_tag(ex_pc, IDX_W);
  assign ex_entry = btb_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);
  assign taken    = (ex_pc_golden != (ex_pc + 32'd4));

  assign train_c   = (state_q == RUN) && ex_valid && ex_is_ctrl;
  assign mispred_c = (state_q == RUN) && ex_valid && (ex_pred_pc != ex_pc_golden);

  sat_ctr2 u_sat_ctr2 (
    .ctr_i   (ex_entry.ctr),
    .taken_i (taken),
    .ctr_o   (ctr_upd)
  );

  // Lookup reads the array before any same-cycle write lands.
  always_comb begin
    if_pred_pc = if_pc + 32'd4;
    if ((state_q != INIT) && if_hit && if_entry.ctr[1]) begin
      if_pred_pc = if_entry.target;
    end
  end

  always_comb begin
    state_d          = state_q;
    init_idx_d       = init_idx_q;
    ready_d          = ready_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    clr_we           = 1'b0;
    btb_we           = 1'b0;
    btb_wdata        = ex_entry;
    unique case (state_q)
      INIT: begin
        clr_we     = 1'b1;
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(BTB_ENTRIES - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (train_c) begin
          if (ex_hit) begin
            btb_we        = 1'b1;
            btb_wdata.ctr = ctr_upd;
            if (taken) btb_wdata.target = ex_pc_golden;
          end else if (taken) begin
            btb_we    = 1'b1;
            btb_wdata = '{valid: 1'b1, tag: ex_tag, target: ex_pc_golden, ctr: CTR_WT};
          end
        end
        if (mispred_c) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = ex_pc_golden;
          state_d          = REDIRECT;
        end
      end
      // EX holds a wrong-path instruction here: no training, no second redirect.
      REDIRECT: state_d = RUN;
      default:  state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= INIT;
      init_idx_q       <= '0;
      ready_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      init_idx_q       <= init_idx_d;
      ready_q          <= ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // BTB storage has no reset; the INIT sweep invalidates every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        btb_q[init_idx_q].valid <= 1'b0;
      end else if (btb_we) begin
        btb_q[ex_idx] <= btb_wdata;
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign ready          = ready_q;

`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_ctrl_cnt_q, perf_mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ctrl_cnt_q    <= '0;
      perf_mispred_cnt_q <= '0;
    end else begin
      if (train_c)   perf_ctrl_cnt_q    <= perf_ctrl_cnt_q + 32'd1;
      if (mispred_c) perf_mispred_cnt_q <= perf_mispred_cnt_q + 32'd1;
    end
  end

  assign perf_ctrl_cnt    = perf_ctrl_cnt_q;
  assign perf_mispred_cnt = perf_mispred_cnt_q;
`endif

endmodule

// File: tb/tb_if_next_pc_predictor.sv
// Bench for if_next_pc_predictor: directed scenarios plus randomized traffic against a table-level BTB model.
module tb_if_next_pc_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_stall;
  logic [31:0] if_pred_pc;
  logic        ex_valid;
  logic        ex_is_ctrl;
  logic [31:0] ex_pc;
  logic [31:0] ex_pred_pc;
  logic [31:0] ex_pc_golden;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;

  if_next_pc_predictor #(.BTB_ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_stall       (if_stall),
    .if_pred_pc     (if_pred_pc),
    .ex_valid       (ex_valid),
    .ex_is_ctrl     (ex_is_ctrl),
    .ex_pc          (ex_pc),
    .ex_pred_pc     (ex_pred_pc),
    .ex_pc_golden   (ex_pc_golden),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ready          (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 16-entry table, counters as plain ints, redirect cycle tracked by the pending flag.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_init_left = 16;
  bit          m_rv = 1'b0;
  logic [31:0] m_rpc = 32'h0;

  function automatic logic [31:0] m_predict(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 32'd16);
    if (m_init_left == 0 && m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2) return m_tgt[i];
    return pc + 32'd4;
  endfunction

  task automatic model_tick();
    int  i;
    bit  tk;
    bit  hit;
    if (rst) begin
      m_init_left = 16;
      m_rv  = 1'b0;
      m_rpc = 32'h0;
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (m_rv) begin
      m_rv = 1'b0;
    end else begin
      if (ex_valid && ex_is_ctrl) begin
        i   = int'((ex_pc >> 2) % 32'd16);
        tk  = (ex_pc_golden != ex_pc + 32'd4);
        hit = m_valid[i] && (m_tag[i] == (ex_pc >> 6));
        if (hit) begin
          if (tk) begin
            if (m_ctr[i] < 3) m_ctr[i]++;
            m_tgt[i] = ex_pc_golden;
          end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
          end
        end else if (tk) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = ex_pc >> 6;
          m_tgt[i]   = ex_pc_golden;
          m_ctr[i]   = 2;
        end
      end
      if (ex_valid && ex_pred_pc != ex_pc_golden) begin
        m_rv  = 1'b1;
        m_rpc = ex_pc_golden;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic c, input logic [31:0] pc,
                        input logic [31:0] pred, input logic [31:0] gold);
    ex_valid = v; ex_is_ctrl = c; ex_pc = pc; ex_pred_pc = pred; ex_pc_golden = gold;
  endtask

  task automatic ex_idle();
    set_ex(1'b0, 1'b0, 32'h0, 32'h4, 32'h4);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    case ($urandom_range(0, 7))
      0:       p = 32'hFFFF_FFFC;
      1, 2:    p = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
      default: p = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
    endcase
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1; if_stall = 1'b0; if_pc = 32'h100; ex_idle();
    step(); step();
    n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", ready); else n_pass++;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv: got %0b want 0", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h0) $display("FAIL reset_rpc: got %h want 0", redirect_pc); else n_pass++;
    rst = 1'b0;
    set_ex(1'b1, 1'b1, 32'h100, 32'h104, 32'h180);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 16) ex_idle();
      n_checks++; if (ready !== (k == 16)) $display("FAIL init_ready cyc%0d: got %0b want %0b", k, ready, (k == 16)); else n_pass++;
      n_checks++; if (redirect_valid !== 1'b0) $display("FAIL init_rv cyc%0d: got %0b want 0", k, redirect_valid); else n_pass++;
      n_checks++; if (if_pred_pc !== 32'h104) $display("FAIL init_pred cyc%0d: got %h want 104", k, if_pred_pc); else n_pass++;
    end
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL init_post_rv: got %0b want 0", redirect_valid); else n_pass++;
  endtask

  task automatic test_train_taken();
    if_pc = 32'h300;
    set_ex(1'b1, 1'b1, 32'h200, 32'h204, 32'h240);
    step();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL taken_rv: got %0b want 1", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h240) $display("FAIL taken_rpc: got %h want 240", redirect_pc); else n_pass++;
    ex_idle(); if_pc = 32'h200; #1;
    n_checks++; if (if_pred_pc !== 32'h240) $display("FAIL taken_pred_redir: got %h want 240", if_pred_pc); else n_pass++;
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL taken_rv_drop: got %0b want 0", redirect_valid); else n_pass++;
    n_checks++; if (if_pred_pc !== 32'h240) $display("FAIL taken_pred_run: got %h want 240", if_pred_pc); else n_pass++;
  endtask

  task automatic test_not_taken_suppressed();
    if_pc = 32'h200;
    set_ex(1'b1, 1'b1, 32'h200, 32'h240, 32'h204);
    step();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL nt_rv: got %0b want 1", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h204) $display("FAIL nt_rpc: got %h want 204", redirect_pc); else n_pass++;
    n_checks++; if (if_pred_pc !== 32'h204) $display("FAIL nt_pred: got %h want 204", if_pred_pc); else n_pass++;
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL nt_second_rv: got %0b want 0", redirect_valid); else n_pass++;
    ex_idle();
    set_ex(1'b1, 1'b1, 32'h200, 32'h204, 32'h240);
    step();
    n_checks++; if (redirect_pc !== 32'h240) $display("FAIL nt_retrain_rpc: got %h want 240", redirect_pc); else n_pass++;
    ex_idle(); #1;
    n_checks++; if (if_pred_pc !== 32'h240) $display("FAIL nt_ctr_not_double_dec: got %h want 240", if_pred_pc); else n_pass++;
    step();
  endtask

  task automatic test_alias();
    if_pc = 32'h240; #1;
    n_checks++; if (if_pred_pc !== 32'h244) $display("FAIL alias_pred: got %h want 244", if_pred_pc); else n_pass++;
    if_pc = 32'h200; #1;
    n_checks++; if (if_pred_pc !== 32'h240) $display("FAIL alias_owner_pred: got %h want 240", if_pred_pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 1'b0, 32'h400, 32'h500, 32'h404);
    step();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL b2b_first_rv: got %0b want 1", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h404) $display("FAIL b2b_first_rpc: got %h want 404", redirect_pc); else n_pass++;
    set_ex(1'b1, 1'b0, 32'h408, 32'h600, 32'h40C);
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL b2b_second_rv: got %0b want 0", redirect_valid); else n_pass++;
    ex_idle();
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL b2b_idle_rv: got %0b want 0", redirect_valid); else n_pass++;
  endtask

  task automatic test_reset_in_redirect();
    set_ex(1'b1, 1'b1, 32'h200, 32'h204, 32'h240);
    step();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL rr_rv: got %0b want 1", redirect_valid); else n_pass++;
    ex_idle(); rst = 1'b1;
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL rr_rv_clear: got %0b want 0", redirect_valid); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL rr_ready: got %0b want 0", ready); else n_pass++;
    rst = 1'b0; if_pc = 32'h200;
    repeat (16) step();
    n_checks++; if (ready !== 1'b1) $display("FAIL rr_ready_back: got %0b want 1", ready); else n_pass++;
    n_checks++; if (if_pred_pc !== 32'h204) $display("FAIL rr_entry_gone: got %h want 204", if_pred_pc); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] want;
    for (int n = 0; n < 600; n++) begin
      n_checks++; if (redirect_valid !== m_rv) $display("FAIL rnd_rv@%0d: got %0b want %0b", n, redirect_valid, m_rv); else n_pass++;
      n_checks++; if (redirect_pc !== m_rpc) $display("FAIL rnd_rpc@%0d: got %h want %h", n, redirect_pc, m_rpc); else n_pass++;
      n_checks++; if (ready !== (m_init_left == 0)) $display("FAIL rnd_ready@%0d: got %0b want %0b", n, ready, (m_init_left == 0)); else n_pass++;
      rst      = ($urandom_range(0, 149) == 0);
      if_stall = $urandom_range(0, 3) == 0;
      if_pc    = rand_pc();
      ex_valid   = $urandom_range(0, 4) != 0;
      ex_is_ctrl = $urandom_range(0, 2) != 0;
      ex_pc      = rand_pc();
      case ($urandom_range(0, 3))
        0, 1:    ex_pc_golden = ex_pc + 32'd4;
        2:       ex_pc_golden = rand_pc();
        default: ex_pc_golden = $urandom();
      endcase
      case ($urandom_range(0, 3))
        0, 1:    ex_pred_pc = m_predict(ex_pc);
        2:       ex_pred_pc = ex_pc + 32'd4;
        default: ex_pred_pc = rand_pc();
      endcase
      #1;
      want = m_predict(if_pc);
      n_checks++; if (if_pred_pc !== want) $display("FAIL rnd_pred@%0d: pc %h got %h want %h", n, if_pc, if_pred_pc, want); else n_pass++;
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_not_taken_suppressed();
    test_alias();
    test_back_to_back();
    test_reset_in_redirect();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
